// File: rtl/fod_cal_seq.sv
// Frequency-hop / calibration bring-up sequencer for the FOD controller.
// Accepts an FCW by handshake, pulses datapath sync resets, then stages calibration enables.
module fod_cal_seq #(
  parameter int WI       = 7,
  parameter int WF       = 16,
  parameter int FCW_RST  = 311296,
  parameter int CNT_W    = 16,
  parameter int SYNC_CYC = 4,
  parameter int PCAL_CYC = 1024,
  parameter int ICAL_CYC = 4096
) (
  input  logic             CLK,
  input  logic             NARST,
  input  logic             SYS_EN,
  input  logic             HOP_REQ,
  input  logic [WI+WF-1:0] FCW_REQ,
  input  logic             DTCCALI_ALLOW,
  input  logic             OFSTCALI_ALLOW,
  input  logic             DSM_SYNC_NRST_EN,
  input  logic             NCO_SYNC_NRST_EN,
  output logic [WI+WF-1:0] FCW_FOD,
  output logic             DSM_NRST,
  output logic             NCO_NRST,
  output logic             PCALI_EN,
  output logic             DTCCALI_EN,
  output logic             OFSTCALI_EN,
  output logic             HOP_ACK,
  output logic             BUSY,
  output logic             LOCK,
  output logic [2:0]       STATE
);

  localparam int FW = WI + WF;
  localparam logic [FW-1:0]    FCW_INIT = FW'(FCW_RST);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC_CYC - 1);
  localparam logic [CNT_W-1:0] PCAL_END = CNT_W'(PCAL_CYC - 1);
  localparam logic [CNT_W-1:0] ICAL_END = CNT_W'(ICAL_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SYNC  = 3'd2,
    PCAL  = 3'd3,
    ICAL  = 3'd4,
    TRACK = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      hold_q, hold_d;
  logic [FW-1:0]      fcw_q, fcw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               dsm_nrst_q, dsm_nrst_d;
  logic               nco_nrst_q, nco_nrst_d;
  logic               pcal_en_q, pcal_en_d;
  logic               dtc_en_q, dtc_en_d;
  logic               ofst_en_q, ofst_en_d;
  logic               busy_q, busy_d;
  logic               lock_q, lock_d;

  // Counter defaults to zero so every state entry starts a fresh dwell.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fcw_d   = fcw_q;
    cnt_d   = '0;
    ack_d   = 1'b0;
    if (!SYS_EN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LOAD;
          hold_d  = FCW_REQ;
        end
        LOAD: begin
          fcw_d   = hold_q;
          state_d = SYNC;
        end
        SYNC: begin
          if (cnt_q == SYNC_END) state_d = PCAL;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        PCAL: begin
          if (cnt_q == PCAL_END)
            state_d = (DTCCALI_ALLOW || OFSTCALI_ALLOW) ? ICAL : TRACK;
          else
            cnt_d = cnt_q + CNT_W'(1);
        end
        ICAL: begin
          if (cnt_q == ICAL_END) state_d = TRACK;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        TRACK: begin
          if (HOP_REQ) begin
            state_d = LOAD;
            hold_d  = FCW_REQ;
            ack_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside STATE.
  always_comb begin
    dsm_nrst_d = 1'b1;
    nco_nrst_d = 1'b1;
    pcal_en_d  = 1'b0;
    dtc_en_d   = 1'b0;
    ofst_en_d  = 1'b0;
    busy_d     = 1'b0;
    lock_d     = 1'b0;
    case (state_d)
      LOAD: busy_d = 1'b1;
      SYNC: begin
        busy_d     = 1'b1;
        dsm_nrst_d = ~DSM_SYNC_NRST_EN;
        nco_nrst_d = ~NCO_SYNC_NRST_EN;
      end
      PCAL: begin
        busy_d    = 1'b1;
        pcal_en_d = 1'b1;
      end
      ICAL: begin
        busy_d    = 1'b1;
        pcal_en_d = 1'b1;
        dtc_en_d  = DTCCALI_ALLOW;
        ofst_en_d = OFSTCALI_ALLOW;
      end
      TRACK: begin
        lock_d    = 1'b1;
        pcal_en_d = 1'b1;
        dtc_en_d  = DTCCALI_ALLOW;
        ofst_en_d = OFSTCALI_ALLOW;
      end
      default: begin
        dsm_nrst_d = 1'b0;
        nco_nrst_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      state_q    <= IDLE;
      hold_q     <= FCW_INIT;
      fcw_q      <= FCW_INIT;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      dsm_nrst_q <= 1'b0;
      nco_nrst_q <= 1'b0;
      pcal_en_q  <= 1'b0;
      dtc_en_q   <= 1'b0;
      ofst_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      fcw_q      <= fcw_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      dsm_nrst_q <= dsm_nrst_d;
      nco_nrst_q <= nco_nrst_d;
      pcal_en_q  <= pcal_en_d;
      dtc_en_q   <= dtc_en_d;
      ofst_en_q  <= ofst_en_d;
      busy_q     <= busy_d;
      lock_q     <= lock_d;
    end
  end

  assign STATE       = state_q;
  assign FCW_FOD     = fcw_q;
  assign DSM_NRST    = dsm_nrst_q;
  assign NCO_NRST    = nco_nrst_q;
  assign PCALI_EN    = pcal_en_q;
  assign DTCCALI_EN  = dtc_en_q;
  assign OFSTCALI_EN = ofst_en_q;
  assign HOP_ACK     = ack_q;
  assign BUSY        = busy_q;
  assign LOCK        = lock_q;

endmodule
